vdiv_lane_sequencer: RTL

Sequencer that shares one scalar `vdiv` floating-point divider across all lanes of a vector divide instruction. It accepts a vector request of LANES operand pairs plus a lane mask, issues active lanes to the divider one at a time over its valid/ready handshakes, and reassembles the quotients. It returns one vector response with a per-lane NaN flag. It sits between the vector issue stage and the single `vdiv` instance.

---
 rtl/vdiv_lane_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vdiv_lane_sequencer.sv
// Shares one scalar vdiv divider across the lanes of a vector divide:
// issues active lanes in ascending order, reassembles quotients and NaN flags.
module vdiv_lane_sequencer #(
    parameter  int EXP_WIDTH  = 8,
    parameter  int MANT_WIDTH = 7,
    parameter  int LANES      = 4,
    localparam int WIDTH      = EXP_WIDTH + MANT_WIDTH + 1
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [LANES*WIDTH-1:0] req_a,
    input  logic [LANES*WIDTH-1:0] req_b,
    input  logic [LANES-1:0]       req_mask,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [LANES*WIDTH-1:0] rsp_result,
    output logic [LANES-1:0]       rsp_nan,
    output logic                   busy,
    output logic                   div_valid_in,
    input  logic                   div_ready_in,
    output logic [WIDTH-1:0]       div_operand1,
    output logic [WIDTH-1:0]       div_operand2,
    input  logic                   div_valid_out,
    output logic                   div_ready_out,
    input  logic [WIDTH-1:0]       div_result
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic is_nan(input logic [EXP_WIDTH-1:0] e, input logic [MANT_WIDTH-1:0] m);
        return (&e) && (|m);
    endfunction

    // {found, index} of the lowest set mask bit at or above 'from'
    function automatic logic [IDX_W:0] next_lane(input logic [LANES-1:0] m, input int from);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (m[i] && (i >= from)) begin
                r = {1'b1, IDX_W'(i)};
            end
        end
        return r;
    endfunction

    state_t                 state_r, state_s;
    logic [IDX_W-1:0]       idx_r, idx_s;
    logic [LANES*WIDTH-1:0] a_r, a_s, b_r, b_s, result_r, result_s;
    logic [LANES-1:0]       mask_r, mask_s, nan_r, nan_s;
    logic [IDX_W:0]         lane_s;
    logic                   req_ready_r, rsp_valid_r, busy_r, div_valid_in_r, div_ready_out_r;
    logic                   req_ready_s, rsp_valid_s, busy_s, div_valid_in_s, div_ready_out_s;
    logic [WIDTH-1:0]       op1_r, op2_r, op1_s, op2_s;

    // State, datapath and registered-output flops
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r         <= ST_IDLE;
            idx_r           <= '0;
            a_r             <= '0;
            b_r             <= '0;
            mask_r          <= '0;
            result_r        <= '0;
            nan_r           <= '0;
            req_ready_r     <= 1'b0;
            rsp_valid_r     <= 1'b0;
            busy_r          <= 1'b0;
            div_valid_in_r  <= 1'b0;
            div_ready_out_r <= 1'b0;
            op1_r           <= '0;
            op2_r           <= '0;
        end else begin
            state_r         <= state_s;
            idx_r           <= idx_s;
            a_r             <= a_s;
            b_r             <= b_s;
            mask_r          <= mask_s;
            result_r        <= result_s;
            nan_r           <= nan_s;
            req_ready_r     <= req_ready_s;
            rsp_valid_r     <= rsp_valid_s;
            busy_r          <= busy_s;
            div_valid_in_r  <= div_valid_in_s;
            div_ready_out_r <= div_ready_out_s;
            op1_r           <= op1_s;
            op2_r           <= op2_s;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        a_s      = a_r;
        b_s      = b_r;
        mask_s   = mask_r;
        result_s = result_r;
        nan_s    = nan_r;
        lane_s   = '0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    a_s      = req_a;
                    b_s      = req_b;
                    mask_s   = req_mask;
                    result_s = req_a;
                    nan_s    = '0;
                    lane_s   = next_lane(req_mask, 0);
                    idx_s    = lane_s[IDX_W-1:0];
                    if (lane_s[IDX_W]) begin
                        state_s = ST_ISSUE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (div_valid_in_r && div_ready_in) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (div_valid_out && div_ready_out_r) begin
                    result_s[int'(idx_r)*WIDTH +: WIDTH] = div_result;
                    nan_s[idx_r] = is_nan(div_result[WIDTH-2 -: EXP_WIDTH], div_result[MANT_WIDTH-1:0]);
                    lane_s = next_lane(mask_r, int'(idx_r) + 1);
                    if (lane_s[IDX_W]) begin
                        idx_s   = lane_s[IDX_W-1:0];
                        state_s = ST_ISSUE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values are derived from the next state so the flops track the state exactly
    always_comb begin
        req_ready_s     = (state_s == ST_IDLE);
        rsp_valid_s     = (state_s == ST_DONE);
        busy_s          = (state_s != ST_IDLE);
        div_valid_in_s  = (state_s == ST_ISSUE);
        div_ready_out_s = (state_s == ST_WAIT);
        op1_s           = a_s[int'(idx_s)*WIDTH +: WIDTH];
        op2_s           = b_s[int'(idx_s)*WIDTH +: WIDTH];
    end

    assign req_ready     = req_ready_r;
    assign rsp_valid     = rsp_valid_r;
    assign busy          = busy_r;
    assign div_valid_in  = div_valid_in_r;
    assign div_ready_out = div_ready_out_r;
    assign div_operand1  = op1_r;
    assign div_operand2  = op2_r;
    assign rsp_result    = result_r;
    assign rsp_nan       = nan_r;

endmodule
